// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store requesters.
// Data has priority; a saturating starve counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  input  logic        imem_flush,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, IDROP} state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       grant_i, grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    case (state)
      IDLE: begin
        if (imem_valid && (!dmem_valid || starve_cnt == LIMIT)) begin
          grant_i   = 1'b1;
          state_nxt = IBUSY;
        end else if (dmem_valid) begin
          grant_d   = 1'b1;
          state_nxt = DBUSY;
        end
      end
      IBUSY: begin
        // A flush lets the memory access finish but never delivers its data.
        if (mem_ready) begin
          imem_ready = !imem_flush;
          state_nxt  = IDLE;
        end else if (imem_flush) begin
          state_nxt = IDROP;
        end
      end
      DBUSY: begin
        if (mem_ready) begin
          dmem_ready = 1'b1;
          state_nxt  = IDLE;
        end
      end
      IDROP: begin
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      starve_cnt <= '0;
    end else if (grant_i) begin
      mem_instr  <= 1'b1;
      mem_addr   <= imem_addr;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      starve_cnt <= '0;
    end else if (grant_d) begin
      mem_instr <= 1'b0;
      mem_addr  <= dmem_addr;
      mem_wdata <= dmem_wdata;
      mem_wstrb <= dmem_wstrb;
      if (imem_valid && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign mem_valid  = (state != IDLE);
  assign imem_rdata = imem_ready ? mem_rdata : '0;
  assign dmem_rdata = dmem_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus reset and contention sequences.
module tb_mem_arbiter;
  logic        clk, rst;
  logic        imem_valid, imem_flush, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_valid, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int nvec = 0;
  int nerr = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_flush(imem_flush),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        fl;
    logic        dv;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] rd;
    logic        mr;
    logic        e_mv;
    logic        e_mi;
    logic [31:0] e_ma;
    logic [31:0] e_mwd;
    logic [3:0]  e_mws;
    logic        e_ir;
    logic        e_dr;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic iv, input logic [31:0] ia, input logic fl, input logic dv,
                     input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] rd, input logic mr,
                     input logic e_mv, input logic e_mi, input logic [31:0] e_ma,
                     input logic [31:0] e_mwd, input logic [3:0] e_mws, input logic e_ir,
                     input logic e_dr, input logic [31:0] e_ird, input logic [31:0] e_drd);
    vec_t r;
    r = '{iv, ia, fl, dv, da, wd, ws, rd, mr, e_mv, e_mi, e_ma, e_mwd, e_mws, e_ir, e_dr, e_ird, e_drd};
    vt.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic fl, input logic dv,
                       input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] rd, input logic mr);
    imem_valid = iv; imem_addr = ia; imem_flush = fl;
    dmem_valid = dv; dmem_addr = da; dmem_wdata = wd; dmem_wstrb = ws;
    mem_rdata = rd; mem_ready = mr;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //   iv  ia         fl dv  da        wd            ws    rd        mr | mv mi ma        mwd           mws   ir dr ird       drd
    // single fetch, memory answers one cycle after mem_valid
    add(1, 32'h100, 0, 0, 0,        0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    add(1, 32'h100, 0, 0, 0,        0,            0,    0,        0,   1, 1, 32'h100,  0,            0,    0, 0, 0,        0);
    add(1, 32'h100, 0, 0, 0,        0,            0,    32'h13,   1,   1, 1, 32'h100,  0,            0,    1, 0, 32'h13,   0);
    add(0, 0,       0, 0, 0,        0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    // store
    add(0, 0,       0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    add(0, 0,       0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 32'h55,   1,   1, 0, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 1, 0,        32'h55);
    add(0, 0,       0, 0, 0,        0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    // both valid: data wins, then the waiting fetch
    add(1, 32'h300, 0, 1, 32'h400,  0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    add(1, 32'h300, 0, 1, 32'h400,  0,            0,    32'hAAAA, 1,   1, 0, 32'h400,  0,            0,    0, 1, 0,        32'hAAAA);
    add(1, 32'h300, 0, 0, 0,        0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    add(1, 32'h300, 0, 0, 0,        0,            0,    32'h77,   1,   1, 1, 32'h300,  0,            0,    1, 0, 32'h77,   0);
    // flush while memory is slow, then refetch at 0x200
    add(1, 32'h180, 0, 0, 0,        0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    add(1, 32'h200, 1, 0, 0,        0,            0,    0,        0,   1, 1, 32'h180,  0,            0,    0, 0, 0,        0);
    add(1, 32'h200, 0, 0, 0,        0,            0,    0,        0,   1, 1, 32'h180,  0,            0,    0, 0, 0,        0);
    add(1, 32'h200, 1, 0, 0,        0,            0,    32'h99,   1,   1, 1, 32'h180,  0,            0,    0, 0, 0,        0);
    add(1, 32'h200, 0, 0, 0,        0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    add(1, 32'h200, 0, 0, 0,        0,            0,    32'h1234, 1,   1, 1, 32'h200,  0,            0,    1, 0, 32'h1234, 0);
    // flush coincident with completion
    add(1, 32'h500, 0, 0, 0,        0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    add(1, 32'h500, 1, 0, 0,        0,            0,    32'h42,   1,   1, 1, 32'h500,  0,            0,    0, 0, 0,        0);
    add(0, 0,       0, 0, 0,        0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    // flush during a data access and while idle has no effect
    add(0, 0,       0, 1, 32'h600,  0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    add(0, 0,       1, 1, 32'h600,  0,            0,    0,        0,   1, 0, 32'h600,  0,            0,    0, 0, 0,        0);
    add(0, 0,       1, 1, 32'h600,  0,            0,    32'h66,   1,   1, 0, 32'h600,  0,            0,    0, 1, 0,        32'h66);
    add(0, 0,       1, 0, 0,        0,            0,    0,        1,   0, 0, 0,        0,            0,    0, 0, 0,        0);
    add(0, 0,       0, 0, 0,        0,            0,    0,        0,   0, 0, 0,        0,            0,    0, 0, 0,        0);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst mem_valid", {31'b0, mem_valid}, 0);
    chk("rst mem_instr", {31'b0, mem_instr}, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_wstrb", {28'b0, mem_wstrb}, 0);
    chk("rst readies", {30'b0, imem_ready, dmem_ready}, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].iv, vt[i].ia, vt[i].fl, vt[i].dv, vt[i].da, vt[i].wd, vt[i].ws, vt[i].rd, vt[i].mr);
      #1;
      chk($sformatf("v%0d mem_valid", i), {31'b0, mem_valid}, {31'b0, vt[i].e_mv});
      chk($sformatf("v%0d imem_ready", i), {31'b0, imem_ready}, {31'b0, vt[i].e_ir});
      chk($sformatf("v%0d dmem_ready", i), {31'b0, dmem_ready}, {31'b0, vt[i].e_dr});
      chk($sformatf("v%0d imem_rdata", i), imem_rdata, vt[i].e_ird);
      chk($sformatf("v%0d dmem_rdata", i), dmem_rdata, vt[i].e_drd);
      if (vt[i].e_mv) begin
        chk($sformatf("v%0d mem_instr", i), {31'b0, mem_instr}, {31'b0, vt[i].e_mi});
        chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].e_ma);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].e_mwd);
        chk($sformatf("v%0d mem_wstrb", i), {28'b0, mem_wstrb}, {28'b0, vt[i].e_mws});
      end
    end

    // asynchronous reset in the middle of a data access
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h700, 0, 0, 0, 0);
    #1 chk("ar idle", {31'b0, mem_valid}, 0);
    @(negedge clk);
    #1 chk("ar dbusy", {31'b0, mem_valid}, 1);
    #1 mem_ready = 1'b1; mem_rdata = 32'hBAD;
    rst = 1'b1;
    #1;
    chk("ar mem_valid", {31'b0, mem_valid}, 0);
    chk("ar dmem_ready", {31'b0, dmem_ready}, 0);
    chk("ar dmem_rdata", dmem_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    dmem_valid = 1'b0;
    #1 chk("ar stale ready", {30'b0, imem_ready, dmem_ready}, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h800, 0, 0, 32'hBAD, 1);
    #1 chk("ar stale ready 2", {31'b0, dmem_ready}, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("ar regrant valid", {31'b0, mem_valid}, 1);
    chk("ar regrant addr", mem_addr, 32'h800);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("ar regrant ready", {31'b0, dmem_ready}, 1);

    // contention: both requesters always valid, grant order D,D,D,D,I repeating
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      drive(1, 32'h1000 + k, 0, 1, 32'h3000 + k, 0, 0, 0, 0);
      #1 chk($sformatf("ct%0d idle gap", k), {31'b0, mem_valid}, 0);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = k;
      #1;
      chk($sformatf("ct%0d mem_instr", k), {31'b0, mem_instr}, (k % 5 == 4) ? 1 : 0);
      chk($sformatf("ct%0d readies", k), {30'b0, imem_ready, dmem_ready},
          (k % 5 == 4) ? 32'd2 : 32'd1);
      chk($sformatf("ct%0d mem_addr", k), mem_addr, (k % 5 == 4) ? 32'h1000 + k : 32'h3000 + k);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
